uart_rx: RTL and testbench

- Serial-to-AXI-Stream receiver; the consuming stage on the far side of the UART link from uart_tx.
- Oversamples `rx` at CLOCKS_PER_PULSE clocks per bit and deserialises NUM_WORDS UART packets, LSB first.
- Assembles them into one W_OUT-bit beat and presents it on an AXIS master port.
- Packet format matches uart_tx: 1 start bit (0), BITS_PER_WORD data bits, then PACKET_SIZE-BITS_PER_WORD-1 end bits (1).

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default link parameters
// common to uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_CLOCKS_PER_PULSE = 4;
  localparam int UART_BITS_PER_WORD    = 8;
  localparam int UART_PACKET_SIZE      = UART_BITS_PER_WORD + 5;
  localparam int UART_W_OUT            = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line. Resets to 1 so an
// idle-high line does not look like a start bit right after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is used by downstream logic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx, deserialises NUM_WORDS packets (LSB first)
// and presents them as one W_OUT-bit beat on an AXI-Stream master port.
//
// Handshake: a beat transfers on any cycle where m_valid & m_ready are both
// high. While m_valid is high m_data is held stable; m_valid never drops
// without a transfer. The receiver is never stalled: a beat completed while
// the previous one is still waiting is dropped and flagged by overflow.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = UART_BITS_PER_WORD,
  parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int W_OUT            = UART_W_OUT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             frame_err,
  output logic             overflow,
  output state_t           dbg_state
);

  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int NUM_END   = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int EW = (NUM_END > 1) ? $clog2(NUM_END) : 1;
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [EW-1:0] END_LAST  = EW'(NUM_END - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

  state_t                   state;
  logic                     rx_s;
  logic [CW-1:0]            clk_cnt;
  logic [BW-1:0]            bit_idx;
  logic [EW-1:0]            end_idx;
  logic [WW-1:0]            word_idx;
  logic [BITS_PER_WORD-1:0] shift;
  logic [W_OUT-1:0]         beat_buf;
  logic [W_OUT-1:0]         beat_full;

  assign dbg_state = state;

  uart_sync2 u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // Beat as it would look with the current word stored into its slot.
  always_comb begin
    beat_full = beat_buf;
    beat_full[int'(word_idx) * BITS_PER_WORD +: BITS_PER_WORD] = shift;
  end

  // Receive FSM plus the AXIS output holding register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      end_idx   <= '0;
      word_idx  <= '0;
      shift     <= '0;
      beat_buf  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            clk_cnt <= '0;
            state   <= START;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;            // too short to be a start bit
            end else begin
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == DATA_LAST) begin
              end_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              word_idx  <= '0;          // partial beat is abandoned
              state     <= WAIT_IDLE;
            end else if (end_idx == END_LAST) begin
              beat_buf <= beat_full;
              state    <= IDLE;
              if (word_idx < WORD_LAST) begin
                word_idx <= word_idx + 1'b1;
              end else begin
                word_idx <= '0;
                if (!m_valid || m_ready) begin
                  m_data  <= beat_full;
                  m_valid <= 1'b1;
                end else begin
                  overflow <= 1'b1;     // keep the waiting beat, drop this one
                end
              end
            end else begin
              end_idx <= end_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial driver tasks, a scoreboard queue of expected
// beats filled at send time, and an independent output monitor.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPP     = 4;
  localparam int BPW     = 8;
  localparam int PS      = BPW + 5;
  localparam int W       = 16;
  localparam int NWORDS  = W / BPW;
  localparam int NUM_END = PS - BPW - 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         rx = 1'b1;
  logic         m_ready = 1'b1;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         frame_err;
  logic         overflow;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  logic [W-1:0] exp_q[$];

  uart_rx #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .PACKET_SIZE      (PS),
    .W_OUT            (W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  // Monitor: counts error pulses and checks every presented beat
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: m_data=%h presented, none expected", m_data);
        end else begin
          if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL beat_data: got %h expected %h", m_data, exp_q[0]);
          end
          if (m_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPP) @(negedge clk);
  endtask

  // One packet: start bit, data LSB first, end bits (bad_end selects a 0)
  task automatic send_word(input logic [BPW-1:0] w, input int bad_end);
    drive_bit(1'b0);
    for (int i = 0; i < BPW; i++) drive_bit(w[i]);
    for (int i = 0; i < NUM_END; i++) drive_bit(i != bad_end);
  endtask

  task automatic send_frame(input logic [W-1:0] beat);
    for (int k = 0; k < NWORDS; k++) send_word(beat[k*BPW +: BPW], -1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, m_valid, 0);
    check({name, "_data"}, m_data, 0);
    check({name, "_ferr"}, frame_err, 0);
    check({name, "_ovf"}, overflow, 0);
    check({name, "_state"}, dbg_state, IDLE);
  endtask

  // Stimulus
  initial begin
    logic [W-1:0] b;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    idle(10);

    // Directed two-word frame
    exp_q.push_back(16'hA55A);
    send_word(8'h5A, -1);
    send_word(8'hA5, -1);
    idle(4);
    wait_drain("drain_a55a");
    check("ferr_after_a55a", ferr_cnt, 0);
    check("ovf_after_a55a", ovf_cnt, 0);

    // Random back-to-back frames
    for (int i = 0; i < 10; i++) begin
      b = W'($urandom);
      exp_q.push_back(b);
      send_frame(b);
    end
    idle(4);
    wait_drain("drain_random");
    check("ferr_after_random", ferr_cnt, 0);

    // Overflow: second beat dropped while first is held
    m_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_frame(16'h1234);
    send_frame(16'hBEEF);
    idle(10);
    check("ovf_count", ovf_cnt, 1);
    check("held_valid", m_valid, 1);
    check("held_data", m_data, 16'h1234);
    m_ready = 1'b1;
    wait_drain("drain_overflow");
    idle(20);
    check("valid_after_overflow", m_valid, 0);

    // One-clock glitch while idle
    rx = 1'b0;
    @(negedge clk);
    idle(10);
    check("glitch_state", dbg_state, IDLE);
    check("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(16'h00FF);
    send_frame(16'h00FF);
    idle(4);
    wait_drain("drain_00ff");

    // Framing error on second end bit of word 0
    send_word(8'h77, 1);
    idle(10);
    check("ferr_count", ferr_cnt, 1);
    check("ferr_state", dbg_state, IDLE);
    exp_q.push_back(16'hC3C3);
    send_frame(16'hC3C3);
    idle(4);
    wait_drain("drain_c3c3");
    check("ferr_after_c3c3", ferr_cnt, 1);

    // Reset during DATA of word 1
    send_word(8'h11, -1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("pre_reset_state", dbg_state, DATA);
    rstn = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset");
    rstn = 1'b1;
    idle(30);
    check("no_stale_valid", m_valid, 0);
    exp_q.push_back(16'h0F0F);
    send_frame(16'h0F0F);
    idle(4);
    wait_drain("drain_0f0f");
    idle(10);
    check("final_ferr", ferr_cnt, 1);
    check("final_ovf", ovf_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
